mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle controller for the `MUL` datapath operation (ALU control code `3'b101`) of the pipelined RSA CPU. It runs a radix-2 shift-add multiply on the captured operands and holds the pipeline with `stall` while the multiply is in progress. It delivers a full-width product to the execute-stage result mux. It sits beside the ALU in the execute stage and is started by the execute-stage control decode.

## Interface
- `WIDTH`, default 32: operand width in bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  execute stage holds a valid `MUL` (ALU control `3'b101`); sampled only in IDLE.
- `op_a`  in  WIDTH  multiplicand (RN value).
- `op_b`  in  WIDTH  multiplier (RD2 value or extended immediate, after the ALUSrc mux).
- `flush`  in  1  pipeline flush (taken jump); aborts any operation in progress.
- `stall`  out  1  freezes fetch, decode and execute pipeline registers.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result_lo`/`result_hi` are valid in this cycle.
- `result_lo`  out  WIDTH  product bits [WIDTH-1:0], written to RD through the ALU result path.
- `result_hi`  out  WIDTH  product bits [2*WIDTH-1:WIDTH], for RSA modular-reduction use.

## Operation
- States are IDLE, RUN and DONE. Encoding is free.
- **IDLE:** when `start` is high and `flush` is low, capture `op_a` into multiplicand register M (zero-extended to 2*WIDTH), capture `op_b` into shift register Q, clear accumulator P, set `count` = 0, and go to RUN.
- **RUN, every edge:**
  - If Q[0] = 1, then P <= P + M. The sum is 2*WIDTH bits and is truncated; it cannot overflow for unsigned operands.
  - M <= M << 1, Q <= Q >> 1, count <= count + 1.
  - When count = WIDTH-1, go to DONE.
- **DONE:** `done` = 1. Go to IDLE on the next edge.
- The product is unsigned. `result_lo` = P[WIDTH-1:0] and `result_hi` = P[2*WIDTH-1:WIDTH]. Both hold their value after DONE until the next accepted `start` clears P.
- `start` is ignored in RUN and DONE. The stalled pipeline re-presents the same `MUL`, and it must not be restarted.
- `start` in the DONE cycle is not accepted. In the cycle after DONE the pipeline has advanced, so a `start` seen in IDLE belongs to a new instruction and is accepted.
- **`flush` in any state:** go to IDLE next edge and suppress `done`. P is undefined after an abort. `flush` has priority over `start`.
- `count` width is clog2(WIDTH)+1. Wrap-around is impossible because count is cleared on every accept.

## Timing
- **Reset (async, immediate):** state = IDLE, P = 0, M = 0, Q = 0, count = 0. Therefore `stall` = 0, `busy` = 0, `done` = 0, `result_lo` = 0, `result_hi` = 0.
- `stall` is combinational: `(state==IDLE && start && !flush) || state==RUN`. The pipeline freezes in the same cycle `start` is first seen.
- Let cycle C0 be the cycle where `start` is accepted. Then:
  - cycles C1..C32 are RUN (WIDTH cycles),
  - C33 is DONE,
  - `stall` is high for C0..C32 (WIDTH+1 cycles) and low in C33, so the pipeline advances at the end of C33 and latches `result_lo`.
- Latency from accept to `done` is WIDTH+1 cycles. Throughput is one multiply per WIDTH+2 cycles.
- `rst` asserted mid-RUN aborts the operation immediately. All outputs return to their reset values while `rst` is high.

## Test plan
- **Reset:** assert `rst` mid-RUN (count = 10) → `stall`, `busy`, `done`, `result_lo` and `result_hi` all read 0 immediately, with no clock edge needed. After release, state is IDLE.
- **Basic multiply:** `start` with `op_a`=7, `op_b`=6 → `stall` high for 33 cycles, then `done` for one cycle with `result_lo`=42 and `result_hi`=0. `done` is never asserted in any other cycle.
- **Full width:** `op_a`=`op_b`=0xFFFFFFFF → `result_hi`=0xFFFFFFFE and `result_lo`=0x00000001. Zero operand (`op_a`=0, `op_b`=0x12345678) → both outputs 0 with the same 33-cycle latency.
- **Start held high:** keep `start` high continuously and change `op_a`/`op_b` during RUN → exactly one multiply of the originally captured operands. The next accept occurs in the cycle after DONE.
- **Flush:** pulse `flush` at count = 5 → IDLE next cycle, `stall` low, no `done` pulse. A `start` together with `flush` in IDLE is not accepted.
- **Back-to-back:** `start` with 3×5 then `start` with 9×9 → `done` pulses carry 15 and then 81. The gap between the two accepts is 34 cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer
// -------------
// Multi-cycle controller for the MUL operation (ALU control 3'b101). It runs a
// radix-2 shift-add unsigned multiply on the captured operands and holds the
// pipeline with stall while the multiply is in progress.
//
// Handshake: start is a level request that is sampled only in IDLE. It is
// accepted when start=1 and flush=0 in IDLE. The result is valid during the
// single-cycle done pulse, and result_lo/result_hi keep that value until the
// next accepted start. There is no back-pressure on done.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      execute stage holds a valid MUL (sampled only in IDLE)
//   op_a       multiplicand (WIDTH bits)
//   op_b       multiplier (WIDTH bits)
//   flush      pipeline flush; aborts any operation, has priority over start
//   stall      freezes fetch/decode/execute registers (combinational)
//   busy       high in RUN and DONE
//   done       one-cycle pulse, product valid in this cycle
//   result_lo  product bits [WIDTH-1:0]
//   result_hi  product bits [2*WIDTH-1:WIDTH]
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [2*WIDTH-1:0] m_reg;   // multiplicand, shifted left each RUN cycle
  logic [2*WIDTH-1:0] p_reg;   // accumulator / product
  logic [WIDTH-1:0]   q_reg;   // multiplier, shifted right each RUN cycle
  logic [CW-1:0]      count;

  logic accept;
  logic last_step;

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign last_step = (count == CW'(WIDTH - 1));

  // Next-state logic. flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. On a flush during RUN the registers simply freeze; the partial
  // product is meaningless after an abort and is cleared on the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= '0;
      p_reg <= '0;
      q_reg <= '0;
      count <= '0;
    end else if (accept) begin
      m_reg <= {{WIDTH{1'b0}}, op_a};
      q_reg <= op_b;
      p_reg <= '0;
      count <= '0;
    end else if ((state == ST_RUN) && !flush) begin
      if (q_reg[0]) begin
        p_reg <= p_reg + m_reg;
      end
      m_reg <= m_reg << 1;
      q_reg <= q_reg >> 1;
      count <= count + CW'(1);
    end
  end

  // stall rises in the same cycle start is first accepted so the MUL is held
  // in execute; it drops in DONE so the pipeline latches result_lo.
  assign stall     = accept || (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign done      = (state == ST_DONE) && !flush;
  assign result_lo = p_reg[WIDTH-1:0];
  assign result_hi = p_reg[2*WIDTH-1:WIDTH];
  assign dbg_state = state;

endmodule
